// File: rtl/icache_refill.sv
// icache_refill: refills one 4-halfword instruction-cache line on a miss.
// Define REFILL_CRITICAL_FIRST_EN to fetch the missing halfword first, wrapping around the line.
module icache_refill (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        lookup_valid,
  input  logic        hit,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] fill_addr,
  output logic [63:0] fill_data,
  output logic        fill_valid,
  output logic        stall
);
  typedef enum logic [1:0] {IDLE, REQ, FILL, WAIT} state_t;
  state_t state;
  logic [15:0] base;
  logic [1:0] cnt, idx_first, idx_next;
  logic [63:0] line, line_w;
  logic unused;
  assign unused = ^pc[2:0];
`ifdef REFILL_CRITICAL_FIRST_EN
  logic [1:0] crit;
  assign idx_first = pc[2:1];
  assign idx_next = crit + cnt + 2'd1;
  always_ff @(posedge clk)
    if (!rst_n) crit <= 2'd0;
    else if (state == IDLE && lookup_valid && !hit) crit <= pc[2:1];
`else
  assign idx_first = 2'd0;
  assign idx_next = cnt + 2'd1;
`endif
  // mem_addr always carries the slot of the halfword currently being fetched
  always_comb begin
    line_w = line;
    line_w[{mem_addr[2:1], 4'b0000} +: 16] = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      stall <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= 16'd0;
      fill_valid <= 1'b0;
      fill_addr <= 16'd0;
      fill_data <= 64'd0;
      cnt <= 2'd0;
      base <= 16'd0;
      line <= 64'd0;
    end else begin
      case (state)
        IDLE: if (lookup_valid && !hit) begin
          base <= {pc[15:3], 3'b000};
          cnt <= 2'd0;
          stall <= 1'b1;
          mem_req <= 1'b1;
          mem_addr <= {pc[15:3], idx_first, 1'b0};
          state <= REQ;
        end
        REQ: if (mem_ack) begin
          line <= line_w;
          cnt <= cnt + 2'd1;
          mem_addr <= {base[15:3], idx_next, 1'b0};
          if (cnt == 2'd3) begin
            mem_req <= 1'b0;
            fill_valid <= 1'b1;
            fill_addr <= base;
            fill_data <= line_w;
            state <= FILL;
          end
        end
        FILL: begin
          fill_valid <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          stall <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
